// File: rtl/booth_r4_seq_multiplier_if.sv
// Start/busy/done handshake bundle for the sequential radix-4 Booth multiplier.
// The control unit drives the master side and the multiplier implements the slave side.
interface booth_r4_seq_multiplier_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   Mplr;
  logic [WIDTH-1:0]   Mcnd;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] Y;

  modport master (
    output start, is_signed, Mplr, Mcnd,
    input  busy, done, Y
  );

  modport slave (
    input  start, is_signed, Mplr, Mcnd,
    output busy, done, Y
  );
endinterface

// File: rtl/booth_r4_seq_multiplier.sv
// Multi-cycle radix-4 Booth multiplier that retires two multiplier bits per clock.
// Signed and unsigned operands are supported; Y holds its value until the next completion.
module booth_r4_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  booth_r4_seq_multiplier_if.slave    bus
);
  localparam int ITER = WIDTH / 2 + 1;
  localparam int EXTW = WIDTH + 2;
  localparam int ACCW = 2 * WIDTH + 4;
  localparam int CNTW = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [EXTW-1:0]    mplr_q;
  logic               prev_q;
  logic [ACCW-1:0]    mcnd_q;
  logic [ACCW-1:0]    acc_q;
  logic [CNTW-1:0]    cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] y_q;

  logic [2:0]         triplet;
  logic [ACCW-1:0]    mcnd_x2;
  logic [ACCW-1:0]    addend_d;
  logic [ACCW-1:0]    acc_d;
  logic [EXTW-1:0]    mplr_ext;
  logic [ACCW-1:0]    mcnd_ext;
  logic               mplr_sign;
  logic               mcnd_sign;

  // Two guard bits make the top Booth triplet see the true sign (or zero) of the operand.
  assign mplr_sign = bus.is_signed & bus.Mplr[WIDTH-1];
  assign mcnd_sign = bus.is_signed & bus.Mcnd[WIDTH-1];
  assign mplr_ext  = {{2{mplr_sign}}, bus.Mplr};
  assign mcnd_ext  = {{(ACCW-WIDTH){mcnd_sign}}, bus.Mcnd};

  assign triplet = {mplr_q[1:0], prev_q};
  assign mcnd_x2 = {mcnd_q[ACCW-2:0], 1'b0};

  always_comb begin
    addend_d = '0;
    case (triplet)
      3'b001, 3'b010: addend_d = mcnd_q;
      3'b011:         addend_d = mcnd_x2;
      3'b100:         addend_d = -mcnd_x2;
      3'b101, 3'b110: addend_d = -mcnd_q;
      default:        addend_d = '0;
    endcase
  end

  assign acc_d = acc_q + addend_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mplr_q  <= '0;
      prev_q  <= 1'b0;
      mcnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mplr_q  <= mplr_ext;
            prev_q  <= 1'b0;
            mcnd_q  <= mcnd_ext;
            acc_q   <= '0;
            cnt_q   <= CNTW'(ITER);
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          // Shifting the multiplicand left by two each step applies the 4^i weight.
          acc_q  <= acc_d;
          mplr_q <= {2'b00, mplr_q[EXTW-1:2]};
          prev_q <= mplr_q[1];
          mcnd_q <= {mcnd_q[ACCW-3:0], 2'b00};
          cnt_q  <= cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) begin
            y_q     <= acc_d[2*WIDTH-1:0];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.Y    = y_q;
endmodule

// File: tb/tb_booth_r4_seq_multiplier.sv
// Scoreboard bench for the radix-4 Booth multiplier: directed WIDTH=32 cases plus
// a randomized WIDTH=8 stream, both checked against plain-arithmetic products.
module tb_booth_r4_seq_multiplier;
  localparam int N32 = 17;
  localparam int N8  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n32;
  logic rst_n8;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  booth_r4_seq_multiplier_if #(.WIDTH(32)) bus32 ();
  booth_r4_seq_multiplier_if #(.WIDTH(8))  bus8 ();

  booth_r4_seq_multiplier #(.WIDTH(32)) u_dut32 (.clk(clk), .reset_n(rst_n32), .bus(bus32));
  booth_r4_seq_multiplier #(.WIDTH(8))  u_dut8  (.clk(clk), .reset_n(rst_n8),  .bus(bus8));

  typedef struct {logic [63:0] y; int s;} exp32_t;
  typedef struct {logic [15:0] y; int s;} exp8_t;
  exp32_t q32[$];
  exp8_t  q8[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref32(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  function automatic logic [15:0] ref8(input bit sgn, input logic [7:0] a, input logic [7:0] b);
    int r;
    if (sgn) r = int'($signed(a)) * int'($signed(b));
    else     r = int'({24'b0, a}) * int'({24'b0, b});
    return r[15:0];
  endfunction

  // ---------------- monitors ----------------
  logic [63:0] last_y32 = '0;
  int          busy_cnt32 = 0;
  always @(negedge clk) begin
    exp32_t e;
    if (!rst_n32) begin
      last_y32   = '0;
      busy_cnt32 = 0;
    end else begin
      check("busy_done_excl32", 64'(bus32.busy & bus32.done), 64'd0);
      if (bus32.busy) busy_cnt32++;
      if (bus32.done) begin
        if (q32.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL done32_unexpected: got done with Y=0x%0h, expected no done", bus32.Y);
        end else begin
          e = q32.pop_front();
          $display("w32 Y=0x%016h exp=0x%016h lat=%0d", bus32.Y, e.y, cyc - e.s);
          check("y32", bus32.Y, e.y);
          check("latency32", 64'(cyc - e.s), 64'(N32));
          check("busy_cycles32", 64'(busy_cnt32), 64'(N32));
        end
        busy_cnt32 = 0;
        last_y32   = bus32.Y;
      end else begin
        check("y_hold32", bus32.Y, last_y32);
      end
    end
  end

  logic [15:0] last_y8 = '0;
  int          busy_cnt8 = 0;
  always @(negedge clk) begin
    exp8_t e;
    if (!rst_n8) begin
      last_y8   = '0;
      busy_cnt8 = 0;
    end else begin
      if (bus8.busy && bus8.done) check("busy_done_excl8", 64'd1, 64'd0);
      if (bus8.busy) busy_cnt8++;
      if (bus8.done) begin
        if (q8.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL done8_unexpected: got done with Y=0x%0h, expected no done", bus8.Y);
        end else begin
          e = q8.pop_front();
          $display("w8 Y=0x%04h exp=0x%04h lat=%0d", bus8.Y, e.y, cyc - e.s);
          check("y8", 64'(bus8.Y), 64'(e.y));
          check("latency8", 64'(cyc - e.s), 64'(N8));
          check("busy_cycles8", 64'(busy_cnt8), 64'(N8));
        end
        busy_cnt8 = 0;
        last_y8   = bus8.Y;
      end else if (bus8.Y !== last_y8) begin
        check("y_hold8", 64'(bus8.Y), 64'(last_y8));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic go32(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    exp32_t e;
    bus32.start     = 1'b1;
    bus32.is_signed = sgn;
    bus32.Mplr      = a;
    bus32.Mcnd      = b;
    e.y = ref32(sgn, a, b);
    e.s = cyc + 1;
    q32.push_back(e);
    @(posedge clk); #1;
    bus32.start = 1'b0;
  endtask

  task automatic wait_done32();
    for (int i = 0; i < 40; i++) begin
      if (bus32.done) return;
      @(posedge clk); #1;
    end
    n_checks++;
    n_fail++;
    $display("FAIL done32_timeout: got no done in 40 cycles, expected done");
  endtask

  task automatic go8(input bit sgn, input logic [7:0] a, input logic [7:0] b);
    exp8_t e;
    bus8.start     = 1'b1;
    bus8.is_signed = sgn;
    bus8.Mplr      = a;
    bus8.Mcnd      = b;
    e.y = ref8(sgn, a, b);
    e.s = cyc + 1;
    q8.push_back(e);
    @(posedge clk); #1;
    bus8.start     = 1'b0;
    bus8.is_signed = 1'($urandom);
    bus8.Mplr      = 8'($urandom);
    bus8.Mcnd      = 8'($urandom);
  endtask

  task automatic wait_done8();
    for (int i = 0; i < 20; i++) begin
      if (bus8.done) return;
      @(posedge clk); #1;
    end
    n_checks++;
    n_fail++;
    $display("FAIL done8_timeout: got no done in 20 cycles, expected done");
  endtask

  function automatic logic [7:0] pick8();
    case ($urandom_range(7))
      0: return 8'h80;
      1: return 8'hFF;
      2: return 8'h7F;
      3: return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n32 = 1'b0;
    rst_n8  = 1'b0;
    bus32.start = 1'b0; bus32.is_signed = 1'b0; bus32.Mplr = '0; bus32.Mcnd = '0;
    bus8.start  = 1'b0; bus8.is_signed  = 1'b0; bus8.Mplr  = '0; bus8.Mcnd  = '0;
    fork
      begin : seq32
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy32", 64'(bus32.busy), 64'd0);
        check("rst_done32", 64'(bus32.done), 64'd0);
        check("rst_y32", bus32.Y, 64'd0);
        rst_n32 = 1'b1;
        @(posedge clk); #1;

        go32(1'b1, 32'hFFFF_FFF9, 32'd6);
        wait_done32();
        check("plan_m7x6", bus32.Y, 64'hFFFF_FFFF_FFFF_FFD6);
        go32(1'b1, 32'h8000_0000, 32'h8000_0000);
        wait_done32();
        check("plan_s_min_sq", bus32.Y, 64'h4000_0000_0000_0000);
        go32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done32();
        check("plan_s_m1_sq", bus32.Y, 64'h0000_0000_0000_0001);
        go32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done32();
        check("plan_u_max_sq", bus32.Y, 64'hFFFF_FFFE_0000_0001);
        repeat (3) @(posedge clk);
        #1;
        go32(1'b0, 32'h8000_0000, 32'd2);
        wait_done32();
        check("plan_u_msb_x2", bus32.Y, 64'h0000_0001_0000_0000);

        // A start pulse and operand change mid-run must have no effect.
        repeat (2) @(posedge clk);
        #1;
        go32(1'b0, 32'd3, 32'd4);
        repeat (5) @(posedge clk);
        #1;
        bus32.start = 1'b1; bus32.is_signed = 1'b1; bus32.Mplr = 32'd5; bus32.Mcnd = 32'd5;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        wait_done32();
        check("plan_ignore_3x4", bus32.Y, 64'd12);
        go32(1'b0, 32'd5, 32'd5);
        wait_done32();
        check("plan_b2b_5x5", bus32.Y, 64'd25);

        // Reset asserted in the eighth RUN cycle discards the operation.
        repeat (2) @(posedge clk);
        #1;
        go32(1'b1, 32'h0001_2345, 32'h0000_0678);
        repeat (7) @(posedge clk);
        #1;
        check("midrun_busy32", 64'(bus32.busy), 64'd1);
        rst_n32 = 1'b0;
        q32.delete();
        #1;
        check("midrst_busy32", 64'(bus32.busy), 64'd0);
        check("midrst_done32", 64'(bus32.done), 64'd0);
        check("midrst_y32", bus32.Y, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n32 = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        go32(1'b0, 32'd2, 32'd3);
        wait_done32();
        check("plan_after_rst_2x3", bus32.Y, 64'd6);
      end
      begin : seq8
        repeat (3) @(posedge clk);
        #1;
        check("rst_y8", 64'(bus8.Y), 64'd0);
        rst_n8 = 1'b1;
        @(posedge clk); #1;
        for (int t = 0; t < 1000; t++) begin
          go8(1'($urandom), pick8(), pick8());
          wait_done8();
          if ($urandom_range(3) == 0) begin
            @(posedge clk); #1;
          end
        end
      end
    join
    repeat (4) @(posedge clk);
    #1;
    check("q32_drained", 64'(q32.size()), 64'd0);
    check("q8_drained", 64'(q8.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/booth_r4_seq_multiplier.md
Name: booth_r4_seq_multiplier

Overview:
Parametrised, multi-cycle radix-4 Booth multiplier; successor to the single-cycle 32-bit Booth multiplier used by the datapath MUL path. Retires two multiplier bits per clock and supports signed and unsigned operands. Uses a start/busy/done handshake so the control unit can stall on it. Result is held stable until the next completion.

Parameters:
WIDTH, 32, operand width in bits; must be even and >= 4. Product width is 2*WIDTH.
ITER, WIDTH/2+1, iteration count N (derived localparam, not overridable).

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only when ready to accept (IDLE or DONE)
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
Mplr  input  WIDTH  multiplier; sampled with start
Mcnd  input  WIDTH  multiplicand; sampled with start
busy  output  1  high while iterating
done  output  1  one-cycle pulse when Y updates
Y  output  2*WIDTH  product, held until next done

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (reset_n=0, any time including mid-operation): state=IDLE, busy=0, done=0, Y=0, all internal registers cleared; operation in flight is discarded, no done pulse afterwards.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 -> latch operands, extend each to WIDTH+2 bits (sign-extend if is_signed, zero-extend otherwise), clear accumulator, load iteration counter=N, go RUN. Otherwise stay.
  - RUN: busy=1. Each cycle decode triplet {m[2i+1], m[2i], m[2i-1]} (m[-1]=0): 000/111 -> +0, 001/010 -> +M, 011 -> +2M, 100 -> -2M, 101/110 -> -M; add to accumulator at weight 4^i; shift multiplier right by 2; decrement counter. After N-th iteration, go DONE.
  - DONE: Y <= low 2*WIDTH bits of accumulator, done=1 for exactly this cycle, busy=0. start=1 here is accepted exactly as in IDLE (back-to-back); else go IDLE.
- Latency: start sampled at edge T -> busy high from T+1 for N cycles -> done high and Y valid in cycle T+N+1. WIDTH=32: N=17, done 18 cycles after start.
- start while busy=1 ignored; operand/is_signed changes during RUN ignored.
- Arithmetic: accumulator at least 2*WIDTH+4 bits, two's complement, wrap-free; result exact for all inputs in both modes (no overflow possible in 2*WIDTH bits).
- Y changes only in DONE cycle or on reset; is never partially updated.
- busy and done never high simultaneously.

Test Plan:
- WIDTH=32, signed, Mplr=-7 (0xFFFFFFF9), Mcnd=6 -> done 18 cycles after start, Y=0xFFFFFFFFFFFFFFD6; busy high exactly 17 cycles.
- Signed 0x80000000 x 0x80000000 -> Y=0x4000000000000000; signed 0xFFFFFFFF x 0xFFFFFFFF -> Y=0x0000000000000001.
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> Y=0xFFFFFFFE00000001; unsigned 0x80000000 x 2 -> Y=0x0000000100000000.
- Start 3x4, then pulse start with 5x5 during RUN -> single done, Y=12; second request ignored. Then start asserted in DONE cycle with 5x5 -> next done 18 cycles later, Y=25.
- Reset_n low mid-RUN (cycle 8) -> busy, done, Y immediately 0; no done after release; new start 2x3 -> Y=6.
- WIDTH=8 instance, N=5: 1000 random signed/unsigned pairs vs. reference model -> all match, done 6 cycles after start.
